// File: rtl/pc_gen_pkg.sv
// Shared constants and next-PC source encoding for the pc_gen block.
// Configuration macro: PC_GEN_RAS_EN (return address stack present when defined).
package pc_gen_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam int          INC_DEF       = 4;
  localparam int unsigned RESET_VEC_DEF = 32'h0000_0000;
  localparam int          RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_REDIR,
    SRC_RAS,
    SRC_SEQ
  } next_src_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack: push, pop or replace-top, saturating count, registered flags.
// Instantiated by pc_gen only when PC_GEN_RAS_EN is defined.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic            r_empty;
  logic            r_full;

  logic [PW-1:0]   w_top_idx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_replace;
  logic            w_do_pop;

  // r_ptr is the next free slot, so the top entry sits one below it.
  assign w_top_idx = r_ptr - PW'(1);
  assign top_o     = r_mem[w_top_idx];
  assign w_do_pop  = pop_i && (r_count != '0);
  assign w_replace = push_i && w_do_pop;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    if (w_replace) begin
      w_ptr_nxt   = r_ptr;
      w_count_nxt = r_count;
    end else if (push_i) begin
      w_ptr_nxt   = r_ptr + PW'(1);
      w_count_nxt = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
    end else if (w_do_pop) begin
      w_ptr_nxt   = w_top_idx;
      w_count_nxt = r_count - CW'(1);
    end
  end

  // NOTE: the entries are reset explicitly because a cleared stack must read back as zeros.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_replace)   r_mem[w_top_idx] <= push_data_i;
      else if (push_i) r_mem[r_ptr]     <= push_data_i;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign empty_o = r_empty;
  assign full_o  = r_full;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: hold/redirect/stall/return/sequential next-PC selection, registered PC.
// Macro PC_GEN_RAS_EN adds the pc_ras return address stack; otherwise call_i/ret_i are ignored.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              INC       = INC_DEF,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  next_src_t       w_src;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ret_hit;
  logic            w_advance;

  assign w_seq_pc = r_pc + XLEN'(INC);

`ifdef PC_GEN_RAS_EN
  logic w_ras_full;

  assign w_ret_hit = ret_i && !w_ras_empty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_advance && call_i),
    .pop_i       (w_advance && ret_i),
    .push_data_i (w_seq_pc),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty),
    .full_o      (w_ras_full)
  );

  assign ras_empty_o = w_ras_empty;
  assign ras_full_o  = w_ras_full;
`else
  logic w_unused;

  assign w_unused    = &{1'b0, call_i, ret_i, w_advance};
  assign w_ret_hit   = 1'b0;
  assign w_ras_top   = '0;
  assign w_ras_empty = 1'b1;
  assign ras_empty_o = 1'b1;
  assign ras_full_o  = 1'b0;
`endif

  always_comb begin
    w_src = SRC_SEQ;
    if (!start_i)        w_src = SRC_HOLD;
    else if (redirect_i) w_src = SRC_REDIR;
    else if (stall_i)    w_src = SRC_HOLD;
    else if (w_ret_hit)  w_src = SRC_RAS;
  end

  always_comb begin
    w_pc_nxt = w_seq_pc;
    case (w_src)
      SRC_HOLD:  w_pc_nxt = r_pc;
      SRC_REDIR: w_pc_nxt = {redirect_pc_i[XLEN-1:2], 2'b00};
      SRC_RAS:   w_pc_nxt = w_ras_top;
      default:   w_pc_nxt = w_seq_pc;
    endcase
  end

  // Only a real advance (return or sequential step) may touch the stack.
  assign w_advance = (w_src == SRC_RAS) || (w_src == SRC_SEQ);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (start_i) r_valid <= 1'b1;
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table of single-cycle vectors plus multi-cycle stack/reset sequences.
// Expectations follow whichever build is compiled (PC_GEN_RAS_EN defined or not).
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit HAS_RAS = 1'b1;
`else
  localparam bit HAS_RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        ras_empty;
  logic        ras_full;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .call_i        (call),
    .ret_i         (ret),
    .pc_o          (pc),
    .pc_valid_o    (pc_valid),
    .ras_empty_o   (ras_empty),
    .ras_full_o    (ras_full)
  );

  typedef struct {
    logic        start, stall, redir;
    logic [31:0] rpc;
    logic        call, ret;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic st, input logic rd, input logic [31:0] p,
                      input logic c, input logic r);
    start = s; stall = st; redir = rd; rpc = p; call = c; ret = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_ret [5];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_000C, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_000C, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b1};

    // Reset state, observed while reset is held.
    #12;
    check("reset_pc", pc, 32'h0);
    check("reset_valid", 32'(pc_valid), 32'h0);
    check("reset_empty", 32'(ras_empty), 32'h1);
    check("reset_full", 32'(ras_full), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].start, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].call, vecs[i].ret);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_valid", i), 32'(pc_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_empty", i), 32'(ras_empty), 32'(vecs[i].exp_empty));
    end
    // A call under redirect must not have pushed: this return is sequential.
    step(1, 0, 0, 0, 0, 1);
    check("redir_call_ignored_pc", pc, 32'h0000_0204);

    // Call, redirect away, return.
    step(1, 0, 1, 32'h20, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    check("call_pc", pc, 32'h24);
    check("call_empty", 32'(ras_empty), HAS_RAS ? 32'h0 : 32'h1);
    step(1, 0, 1, 32'h80, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    check("ret_pc", pc, HAS_RAS ? 32'h24 : 32'h84);
    check("ret_empty", 32'(ras_empty), 32'h1);

    // Overflow: five calls into a four-deep stack, then five returns.
    step(1, 0, 1, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 1, 0);
      check($sformatf("ovf_call%0d_pc", i), pc, 32'(4 * (i + 1)));
      check($sformatf("ovf_call%0d_full", i), 32'(ras_full), (HAS_RAS && i >= 3) ? 32'h1 : 32'h0);
    end
    if (HAS_RAS) exp_ret = '{32'h14, 32'h10, 32'hC, 32'h8, 32'hC};
    else         exp_ret = '{32'h18, 32'h1C, 32'h20, 32'h24, 32'h28};
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 1);
      check($sformatf("ovf_ret%0d_pc", i), pc, exp_ret[i]);
      check($sformatf("ovf_ret%0d_full", i), 32'(ras_full), 32'h0);
    end
    check("ovf_end_empty", 32'(ras_empty), 32'h1);

    // Call and return together with a non-empty stack: jump to top, top replaced.
    step(1, 0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 32'h500, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    check("callret_pc", pc, HAS_RAS ? 32'h304 : 32'h504);
    check("callret_empty", 32'(ras_empty), HAS_RAS ? 32'h0 : 32'h1);
    step(1, 0, 0, 0, 0, 1);
    check("callret_ret_pc", pc, HAS_RAS ? 32'h504 : 32'h508);
    check("callret_ret_empty", 32'(ras_empty), 32'h1);

    // Call and return together with an empty stack: push only.
    step(1, 0, 0, 0, 1, 1);
    check("callret_empty_pc", pc, HAS_RAS ? 32'h508 : 32'h50C);
    check("callret_empty_flag", 32'(ras_empty), HAS_RAS ? 32'h0 : 32'h1);
    step(1, 0, 0, 0, 0, 1);
    check("callret_empty_ret_pc", pc, HAS_RAS ? 32'h508 : 32'h510);

    // Two entries on the stack, freeze with start low, then asynchronous reset mid-cycle.
    step(1, 0, 1, 32'h600, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    check("pre_reset_pc", pc, 32'h608);
    check("pre_reset_empty", 32'(ras_empty), HAS_RAS ? 32'h0 : 32'h1);
    step(0, 0, 1, 32'h900, 1, 1);
    check("frozen_pc", pc, 32'h608);
    check("frozen_empty", 32'(ras_empty), HAS_RAS ? 32'h0 : 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_valid", 32'(pc_valid), 32'h0);
    check("async_reset_empty", 32'(ras_empty), 32'h1);
    check("async_reset_full", 32'(ras_full), 32'h0);
    #3;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 1);
    check("post_reset_pc", pc, 32'h4);
    check("post_reset_valid", 32'(pc_valid), 32'h1);
    check("post_reset_empty", 32'(ras_empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
